// File: rtl/rv32_branch_pkg.sv
// Shared definitions for the EX-stage branch resolution logic.
//   - funct3 encodings of the RV32I conditional branches
//   - resolution FSM state type
//   - helper telling whether a B-type funct3 is a defined condition
package rv32_branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    // 010/011 are not branch conditions; such an encoding never takes.
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Branch condition evaluator.
// Ports:
//   reg1, reg2 : operands (rs1, rs2)
//   funct3     : B-type condition code
//   result     : 1 when the condition holds (0 for undefined codes)
module branch_compare
    import rv32_branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic [2:0]      funct3,
    output logic            result
);

    always_comb begin
        result = 1'b0;
        case (funct3)
            F3_BEQ:  result = (reg1 == reg2);
            F3_BNE:  result = (reg1 != reg2);
            F3_BLT:  result = ($signed(reg1) <  $signed(reg2));
            F3_BGE:  result = ($signed(reg1) >= $signed(reg2));
            F3_BLTU: result = (reg1 <  reg2);
            F3_BGEU: result = (reg1 >= reg2);
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch/jump resolution controller (static predict-not-taken).
// Resolves the EX instruction once as it leaves EX, and for a taken, aligned
// target issues a registered PC redirect together with IF/ID, ID/EX and EX/MEM
// flushes that hold until the first un-stalled cycle. Misaligned taken targets
// raise a one-cycle target_misalign pulse instead of redirecting.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   stall                  : pipeline hold; EX frozen this cycle
//   ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3 : EX decode info
//   ex_rs1, ex_rs2, ex_pc, ex_imm                            : EX operands
//   redirect_valid, redirect_target                          : PC redirect
//   flush_if_id, flush_id_ex, flush_ex_mem                   : squashes
//   target_misalign                                          : misaligned target pulse
//   branch_count, taken_count                                : saturating perf counters
module branch_resolve_ctrl
    import rv32_branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             target_misalign,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    br_state_e        state_q, state_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic             cmp_result;
    logic             resolve;
    logic             is_taken;
    logic             aligned;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  target;

    branch_compare #(
        .XLEN (XLEN)
    ) u_branch_compare (
        .reg1   (ex_rs1),
        .reg2   (ex_rs2),
        .funct3 (ex_funct3),
        .result (cmp_result)
    );

    // Resolution: only in IDLE, so the wrong-path instruction sitting in EX
    // during FLUSH is never resolved or counted; stall defers it to the cycle
    // the instruction actually leaves EX.
    always_comb begin
        resolve  = (state_q == IDLE) && !stall && ex_valid &&
                   (ex_is_branch || ex_is_jal || ex_is_jalr);
        is_taken = ex_is_jal || ex_is_jalr ||
                   (ex_is_branch && cmp_result && f3_is_legal(ex_funct3));
        jalr_sum = ex_rs1 + ex_imm;
        target   = ex_is_jalr ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                              : (ex_pc + ex_imm);
        aligned  = (target[1:0] == 2'b00);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            target_q       <= '0;
            misalign_q     <= 1'b0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            misalign_q     <= misalign_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    // Next-state / datapath
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        misalign_d     = 1'b0;
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;

        case (state_q)
            IDLE: begin
                if (resolve && is_taken && aligned) begin
                    state_d  = FLUSH;
                    target_d = target;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (resolve) begin
            misalign_d = is_taken && !aligned;
            if (branch_count_q != '1) begin
                branch_count_d = branch_count_q + CNT_W'(1);
            end
            if (is_taken && (taken_count_q != '1)) begin
                taken_count_d = taken_count_q + CNT_W'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        redirect_valid  = (state_q == FLUSH);
        flush_if_id     = (state_q == FLUSH);
        flush_id_ex     = (state_q == FLUSH);
        flush_ex_mem    = (state_q == FLUSH);
        redirect_target = target_q;
        // Gated so the pulse is already low during the reset cycle itself.
        target_misalign = misalign_q && reset_n;
        branch_count    = branch_count_q;
        taken_count     = taken_count_q;
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;

    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        flush_ex_mem;
    logic        target_misalign;
    logic [15:0] branch_count;
    logic [15:0] taken_count;

    logic        b_redirect_valid;
    logic [31:0] b_redirect_target;
    logic        b_flush_if_id;
    logic        b_flush_id_ex;
    logic        b_flush_ex_mem;
    logic        b_target_misalign;
    logic [1:0]  b_branch_count;
    logic [1:0]  b_taken_count;

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .target_misalign(target_misalign), .branch_count(branch_count),
        .taken_count(taken_count)
    );

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .stall(stall), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .redirect_valid(b_redirect_valid), .redirect_target(b_redirect_target),
        .flush_if_id(b_flush_if_id), .flush_id_ex(b_flush_id_ex), .flush_ex_mem(b_flush_ex_mem),
        .target_misalign(b_target_misalign), .branch_count(b_branch_count),
        .taken_count(b_taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: "is a redirect pending", its target, the
    // misalign pulse and plain integer counters saturating at 2^W-1.
    bit          m_flush;
    logic [31:0] m_tgt;
    bit          m_mis;
    int          m_bc, m_tc, m_bc2, m_tc2;

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic model_step();
        bit          tk;
        bit          nmis;
        logic [31:0] t;
        nmis = 1'b0;
        if (!reset_n) begin
            m_flush = 1'b0; m_tgt = '0; m_mis = 1'b0;
            m_bc = 0; m_tc = 0; m_bc2 = 0; m_tc2 = 0;
        end else begin
            if (m_flush) begin
                if (!stall) m_flush = 1'b0;
            end else if (!stall && ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
                tk = ex_is_jal || ex_is_jalr ||
                     (ex_is_branch && ref_taken(ex_funct3, ex_rs1, ex_rs2));
                t  = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
                m_bc  = sat_inc(m_bc, 65535);
                m_bc2 = sat_inc(m_bc2, 3);
                if (tk) begin
                    m_tc  = sat_inc(m_tc, 65535);
                    m_tc2 = sat_inc(m_tc2, 3);
                    if (t[1:0] == 2'b00) begin
                        m_flush = 1'b1;
                        m_tgt   = t;
                    end else begin
                        nmis = 1'b1;
                    end
                end
            end
            m_mis = nmis;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("redirect_valid",  32'(redirect_valid), 32'(m_flush));
        chk("flush_if_id",     32'(flush_if_id),    32'(m_flush));
        chk("flush_id_ex",     32'(flush_id_ex),    32'(m_flush));
        chk("flush_ex_mem",    32'(flush_ex_mem),   32'(m_flush));
        chk("redirect_target", redirect_target,     m_tgt);
        chk("target_misalign", 32'(target_misalign), 32'(m_mis && reset_n));
        chk("branch_count",    32'(branch_count),   32'(m_bc));
        chk("taken_count",     32'(taken_count),    32'(m_tc));
        chk("b_redirect_valid", 32'(b_redirect_valid), 32'(m_flush));
        chk("b_branch_count",  32'(b_branch_count), 32'(m_bc2));
        chk("b_taken_count",   32'(b_taken_count),  32'(m_tc2));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm);
        ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_funct3 = f3; ex_rs1 = rs1; ex_rs2 = rs2; ex_pc = pc; ex_imm = imm;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0);
    endtask

    typedef struct {
        logic        br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        exp_rd;
        logic [31:0] exp_tgt;
        logic        exp_mis;
    } vec_t;

    vec_t vt[10];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int          cnt;
        int          kind;
        int          sel;
        int          bc0;
        logic [31:0] tgt0;

        //         br   jal  jalr f3    rs1           rs2          pc           imm           rd   tgt          mis
        vt[0] = '{1'b1,1'b0,1'b0,3'd0,32'd10,       32'd10,      32'h100,     32'h20,       1'b1,32'h120,     1'b0};
        vt[1] = '{1'b1,1'b0,1'b0,3'd1,32'd10,       32'd10,      32'h100,     32'h20,       1'b0,32'h0,       1'b0};
        vt[2] = '{1'b1,1'b0,1'b0,3'd6,32'd30,       32'd20,      32'h100,     32'h20,       1'b0,32'h0,       1'b0};
        vt[3] = '{1'b1,1'b0,1'b0,3'd5,32'hFFFFFFFB, 32'd3,       32'h100,     32'h20,       1'b0,32'h0,       1'b0};
        vt[4] = '{1'b1,1'b0,1'b0,3'd7,32'hFFFFFFFB, 32'd3,       32'h200,     32'h40,       1'b1,32'h240,     1'b0};
        vt[5] = '{1'b0,1'b0,1'b1,3'd0,32'h201,      32'd0,       32'h500,     32'd3,        1'b1,32'h204,     1'b0};
        vt[6] = '{1'b0,1'b1,1'b0,3'd0,32'd0,        32'd0,       32'h100,     32'd6,        1'b0,32'h0,       1'b1};
        vt[7] = '{1'b1,1'b0,1'b0,3'd2,32'd7,        32'd7,       32'h100,     32'h20,       1'b0,32'h0,       1'b0};
        vt[8] = '{1'b1,1'b0,1'b0,3'd4,32'hFFFFFFFB, 32'd3,       32'h300,     32'hFFFFFFF8, 1'b1,32'h2F8,     1'b0};
        vt[9] = '{1'b0,1'b0,1'b1,3'd0,32'h1000,     32'd0,       32'h40,      32'd2,        1'b0,32'h0,       1'b1};

        m_flush = 1'b0; m_tgt = '0; m_mis = 1'b0;
        m_bc = 0; m_tc = 0; m_bc2 = 0; m_tc2 = 0;
        reset_n = 1'b0; stall = 1'b0;
        idle_inputs();
        cycle();
        cycle();
        chk("reset_redirect_target", redirect_target, 32'h0);
        chk("reset_branch_count", 32'(branch_count), 32'd0);
        reset_n = 1'b1;
        cycle();

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vt[i].br, vt[i].jal, vt[i].jalr, vt[i].f3,
                  vt[i].rs1, vt[i].rs2, vt[i].pc, vt[i].imm);
            cycle();
            chk($sformatf("vec%0d_redirect", i), 32'(redirect_valid), 32'(vt[i].exp_rd));
            chk($sformatf("vec%0d_misalign", i), 32'(target_misalign), 32'(vt[i].exp_mis));
            if (vt[i].exp_rd) chk($sformatf("vec%0d_target", i), redirect_target, vt[i].exp_tgt);
            idle_inputs();
            cycle();
            chk($sformatf("vec%0d_oneshot", i), 32'(redirect_valid | target_misalign), 32'd0);
            cycle();
        end
        chk("table_branch_count", 32'(branch_count), 32'd10);
        chk("table_taken_count",  32'(taken_count),  32'd6);

        // Flush held across 3 stall cycles after the resolve edge
        bc0 = int'(branch_count);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd5, 32'd5, 32'h800, 32'h40);
        cycle();
        tgt0 = redirect_target;
        cnt = int'(redirect_valid);
        stall = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h900, 32'h100);
        for (int k = 0; k < 3; k++) begin
            cycle();
            cnt += int'(redirect_valid);
            chk("stall_target_hold", redirect_target, tgt0);
        end
        stall = 1'b0;
        idle_inputs();
        cycle();
        chk("stall_flush_cycles", 32'(cnt), 32'd4);
        chk("stall_exit_redirect", 32'(redirect_valid), 32'd0);
        chk("stall_target", tgt0, 32'h840);
        chk("stall_count_once", 32'(branch_count), 32'(bc0 + 1));

        // Taken JAL in EX during FLUSH is ignored
        bc0 = int'(branch_count);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd1, 32'd2, 32'hA00, 32'h10);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h400, 32'h10);
        cycle();
        idle_inputs();
        cycle();
        chk("wrongpath_no_redirect", 32'(redirect_valid), 32'd0);
        chk("wrongpath_target", redirect_target, 32'hA10);
        chk("wrongpath_count", 32'(branch_count), 32'(bc0 + 1));

        // Branch held in EX under stall resolves and counts once
        bc0 = int'(branch_count);
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd9, 32'd9, 32'hB00, 32'h8);
        for (int k = 0; k < 3; k++) cycle();
        chk("held_no_early_redirect", 32'(redirect_valid), 32'd0);
        stall = 1'b0;
        cycle();
        chk("held_redirect", 32'(redirect_valid), 32'd1);
        idle_inputs();
        cycle();
        chk("held_count_once", 32'(branch_count), 32'(bc0 + 1));

        // Reset in the middle of FLUSH
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'hC00, 32'h20);
        cycle();
        idle_inputs();
        reset_n = 1'b0;
        cycle();
        chk("rst_flush_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_flush_target", redirect_target, 32'd0);
        chk("rst_flush_taken", 32'(taken_count), 32'd0);
        reset_n = 1'b1;
        cycle();

        // Counter saturation: 5 taken branches, CNT_W=2 copy sticks at 3
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd1, 32'd1, 32'h100, 32'h4);
            cycle();
            idle_inputs();
            cycle();
        end
        chk("sat_b_branch", 32'(b_branch_count), 32'd3);
        chk("sat_b_taken",  32'(b_taken_count),  32'd3);
        chk("sat_a_taken",  32'(taken_count),    32'd5);

        // Randomized stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            reset_n  = ($urandom_range(0, 59) != 0);
            stall    = ($urandom_range(0, 9) < 3);
            ex_valid = ($urandom_range(0, 4) != 0);
            kind     = int'($urandom_range(0, 3));
            ex_is_branch = (kind == 1);
            ex_is_jal    = (kind == 2);
            ex_is_jalr   = (kind == 3);
            ex_funct3    = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: begin ex_rs1 = $urandom; ex_rs2 = ex_rs1; end
                1: begin ex_rs1 = $urandom; ex_rs2 = $urandom; end
                2: begin ex_rs1 = 32'(0) - 32'($urandom_range(1, 20)); ex_rs2 = 32'($urandom_range(0, 20)); end
                default: begin ex_rs1 = 32'($urandom_range(0, 20)); ex_rs2 = 32'hFFFF0000 | $urandom_range(0, 255); end
            endcase
            ex_pc  = $urandom & 32'h0000FFFC;
            ex_imm = 32'($urandom_range(0, 127)) - 32'd64;
            if ($urandom_range(0, 2) != 0) ex_imm = ex_imm & ~32'd3;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
